// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared definitions for the two-requester AXI-Stream packet arbiter:
// FSM state encoding and the default USB high-speed bulk max packet size.
package axis_pkt_arbiter_pkg;

  // Arbiter FSM states: idle/arbitrating, or locked onto requester 0 or 1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL0 = 2'd1,
    ST_SEL1 = 2'd2
  } state_t;

  // USB 2.0 high-speed bulk endpoint max packet size, in beats.
  localparam int HS_BULK_MAX_PKT = 512;

endpackage

// File: rtl/axis_pkt_arbiter.sv
// Two-input AXI-Stream packet arbiter feeding a USB bulk-IN endpoint.
// Round-robin grant per packet, held until the output tlast handshake;
// the 2:1 stream mux is purely combinational once a requester is granted.
// Optional macro PKT_SPLIT_EN: split long source packets into MAX_PKT-beat
// output packets, each split point re-arbitrating like a real end of packet.
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_PKT = HS_BULK_MAX_PKT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             configured_i,
  input  logic             s0_tvalid_i,
  output logic             s0_tready_o,
  input  logic             s0_tlast_i,
  input  logic [WIDTH-1:0] s0_tdata_i,
  input  logic             s1_tvalid_i,
  output logic             s1_tready_o,
  input  logic             s1_tlast_i,
  input  logic [WIDTH-1:0] s1_tdata_i,
  output logic             m_axis_tvalid_o,
  input  logic             m_axis_tready_i,
  output logic             m_axis_tlast_o,
  output logic [WIDTH-1:0] m_axis_tdata_o,
  output logic [1:0]       grant_o,
  output logic             busy_o
);

  // A split point needs at least two beats per packet to be meaningful.
  if (MAX_PKT < 2) begin : g_max_pkt_check
    $error("axis_pkt_arbiter: MAX_PKT must be at least 2");
  end

  state_t state_q, state_d;
  logic   last_q, last_d;  // index of the requester that owned the last packet
  logic   src_last;        // tlast of the selected source
  logic   handshake;
  logic   end_of_pkt;

`ifdef PKT_SPLIT_EN
  localparam int               CNT_W    = $clog2(MAX_PKT) + 1;
  localparam logic [CNT_W-1:0] SPLIT_AT = CNT_W'(MAX_PKT - 1);

  logic [CNT_W-1:0] beat_cnt_q;

  // Beats accepted in the current output packet; parked at zero while idle,
  // so it is already clear on every entry to SEL0/SEL1.
  always_ff @(posedge clock) begin
    if (!reset_n || state_q == ST_IDLE) begin
      beat_cnt_q <= '0;
    end else if (handshake) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Output tlast: source end of packet, or the MAX_PKT-th beat.
  always_comb begin
    m_axis_tlast_o = (state_q != ST_IDLE) && (src_last || beat_cnt_q == SPLIT_AT);
  end
`else
  // Output tlast passes straight through from the selected source.
  always_comb begin
    m_axis_tlast_o = src_last;
  end
`endif

  // 2:1 stream mux and grant decode, driven purely by the registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    s0_tready_o     = 1'b0;
    s1_tready_o     = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    src_last        = 1'b0;
    grant_o         = 2'b00;
    case (state_q)
      ST_SEL0: begin
        m_axis_tvalid_o = s0_tvalid_i;
        m_axis_tdata_o  = s0_tdata_i;
        src_last        = s0_tlast_i;
        s0_tready_o     = m_axis_tready_i;
        grant_o         = 2'b01;
      end
      ST_SEL1: begin
        m_axis_tvalid_o = s1_tvalid_i;
        m_axis_tdata_o  = s1_tdata_i;
        src_last        = s1_tlast_i;
        s1_tready_o     = m_axis_tready_i;
        grant_o         = 2'b10;
      end
      default: ;
    endcase
  end

  assign handshake  = m_axis_tvalid_o & m_axis_tready_i;
  assign end_of_pkt = handshake & m_axis_tlast_o;
  assign busy_o     = (state_q != ST_IDLE);

  // Next-state logic: round-robin grant from IDLE, hold until end of packet.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (configured_i) begin
          if (s0_tvalid_i && s1_tvalid_i) begin
            state_d = last_q ? ST_SEL0 : ST_SEL1;
          end else if (s0_tvalid_i) begin
            state_d = ST_SEL0;
          end else if (s1_tvalid_i) begin
            state_d = ST_SEL1;
          end
        end
      end
      ST_SEL0: begin
        if (end_of_pkt) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_SEL1: begin
        if (end_of_pkt) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and last-owner registers; reset makes requester 0 win the first tie.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
